vga_compositor: RTL and testbench
=================================

# vga_compositor

Parametrised pixel-output stage between the VGA scan generator / per-layer renderers and the VGA pins. Merges NUM_LAYERS sprite layers over a background by fixed priority, with per-layer enable and colour-key transparency. Configuration changes apply only at frame boundaries (tear-free). Sync/DE are delayed through a PIPE_STAGES-deep pipeline so they stay aligned with the colour.

## Interface
- NUM_LAYERS, 4: number of overlay layers; layer 0 has highest priority (2..8 supported).
- COLOR_W, 16: pixel colour width (RGB565 at default).
- PIPE_STAGES, 2: input-to-output latency in cycles (1..4).
- KEY_COLOR, 16'hF81F: transparent colour when keying is enabled; width COLOR_W.
- SYNC_IDLE, 1'b1: reset/idle level of vga_hsync and vga_vsync.

- pix_clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- raw_hsync  in  1  hsync from scan generator.
- raw_vsync  in  1  vsync from scan generator.
- raw_de  in  1  data enable from scan generator.
- new_frame  in  1  one-cycle pulse at frame start.
- layer_pe  in  NUM_LAYERS  per-layer paint enable; bit i belongs to layer i.
- layer_color  in  NUM_LAYERS*COLOR_W  packed layer colours; layer i in bits [i*COLOR_W +: COLOR_W].
- background_color  in  COLOR_W  colour used when no layer paints.
- cfg_valid  in  1  one-cycle strobe that writes cfg_layer_en and cfg_key_en into the pending register.
- cfg_layer_en  in  NUM_LAYERS  requested per-layer enables.
- cfg_key_en  in  1  requested colour-key enable.
- cfg_pending  out  1  pending config not yet applied.
- active_layer_en  out  NUM_LAYERS  enables currently in effect.
- frame_count  out  16  frames since reset.
- vga_hsync, vga_vsync, vga_de  out  1 each  aligned sync and DE.
- vga_rgb  out  COLOR_W  composited pixel.

## Operation
- Config registers:
  - Pending register: {pend_en, pend_key}, loaded on cfg_valid. Later writes overwrite earlier ones; the last write wins.
  - Active register: {act_en, act_key}.
  - On new_frame with cfg_pending=1, pending is copied to active and cfg_pending clears.
  - cfg_valid and new_frame in the same cycle: the cfg_* input values go straight into active, and cfg_pending stays 0.
  - cfg_valid without new_frame sets cfg_pending=1.
- Layer qualification: layer i is visible iff layer_pe[i] && act_en[i] && !(act_key && layer_color[i]==KEY_COLOR).
- Priority select: the lowest-index visible layer wins. If no layer is visible, background_color is used. Keyed pixels fall through to lower-priority layers or the background.
- Output colour: vga_rgb = composited colour when the delayed DE is 1, else 0.
- frame_count: increments by 1 on each new_frame and wraps from 16'hFFFF to 0.
- Reset values:
  - vga_hsync = vga_vsync = SYNC_IDLE; vga_de = 0; vga_rgb = 0.
  - All pipeline stages are cleared to the same values.
  - act_en = all ones, act_key = 0.
  - Pending cleared; cfg_pending = 0; frame_count = 0.
- Reset mid-frame: outputs return to reset values asynchronously. A pending config is discarded.

## Timing
- Latency: the pixel, sync and DE presented at cycle t appear on the outputs at t+PIPE_STAGES.
- Pipeline structure:
  - Stage 1 registers the qualified/priority result together with sync/DE.
  - Stages 2..PIPE_STAGES are pure delay.
- Active config takes effect for inputs sampled on the cycle after the new_frame edge that applies it. The new_frame-cycle pixel still uses the old config.
- active_layer_en, cfg_pending and frame_count update one cycle after the causing event (registered outputs).
- No combinational path exists from any input to any output.

## Test plan
- Reset, defaults: rst=1 → syncs=1, de=0, rgb=0, frame_count=0, active_layer_en=4'hF. Release rst, drive raw_de=1, no pe, background=16'h07E0 → vga_rgb=16'h07E0 exactly 2 cycles later, syncs aligned.
- Priority: layer_pe=4'b0110, layer1=16'h001F, layer2=16'hF800 → rgb=16'h001F. Drop pe[1] → rgb=16'hF800.
- Colour key: cfg_key_en=1 applied at new_frame, layer0=16'hF81F, layer3=16'h1234, pe=4'b1001 → rgb=16'h1234. With key disabled → rgb=16'hF81F.
- Frame-deferred config: cfg_valid with en=4'b1110 mid-frame → cfg_pending=1 and layer0 still shown until new_frame. From the next pixel, layer0 is hidden and cfg_pending=0. Same-cycle cfg_valid+new_frame → applied immediately, cfg_pending stays 0.
- Blanking/wrap: raw_de=0 with pe active → rgb=0. Preload 16'hFFFF frames (or force) and pulse new_frame → frame_count=0.
- Async reset mid-frame with cfg_pending=1 → outputs at reset values the same cycle, pending cleared, active_layer_en=all ones.

Source files
------------

// File: rtl/vga_compositor.sv
// vga_compositor: priority sprite-layer compositor with frame-deferred config and aligned sync pipeline
module vga_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W = 16,
  parameter int PIPE_STAGES = 2,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 16'hF81F,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic                          pix_clk,
  input  logic                          rst,
  input  logic                          raw_hsync,
  input  logic                          raw_vsync,
  input  logic                          raw_de,
  input  logic                          new_frame,
  input  logic [NUM_LAYERS-1:0]         layer_pe,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
  input  logic [COLOR_W-1:0]            background_color,
  input  logic                          cfg_valid,
  input  logic [NUM_LAYERS-1:0]         cfg_layer_en,
  input  logic                          cfg_key_en,
  output logic                          cfg_pending,
  output logic [NUM_LAYERS-1:0]         active_layer_en,
  output logic [15:0]                   frame_count,
  output logic                          vga_hsync,
  output logic                          vga_vsync,
  output logic                          vga_de,
  output logic [COLOR_W-1:0]            vga_rgb
);
  localparam int W = COLOR_W + 3;
  localparam logic [W-1:0] IDLE = {SYNC_IDLE, SYNC_IDLE, 1'b0, {COLOR_W{1'b0}}};
  logic [NUM_LAYERS-1:0] pend_en, act_en;
  logic pend_key, act_key;
  logic [COLOR_W-1:0] pix;
  logic [W-1:0] pipe [PIPE_STAGES];
  // Config pending/active registers; new config only lands on a frame boundary
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      pend_en <= '0;
      pend_key <= 1'b0;
      act_en <= '1;
      act_key <= 1'b0;
      cfg_pending <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      if (cfg_valid) {pend_en, pend_key} <= {cfg_layer_en, cfg_key_en};
      if (new_frame) frame_count <= frame_count + 16'd1;
      if (new_frame && cfg_valid) begin
        {act_en, act_key} <= {cfg_layer_en, cfg_key_en};
        cfg_pending <= 1'b0;
      end else if (new_frame && cfg_pending) begin
        {act_en, act_key} <= {pend_en, pend_key};
        cfg_pending <= 1'b0;
      end else if (cfg_valid) begin
        cfg_pending <= 1'b1;
      end
    end
  end
  assign active_layer_en = act_en;
  // Priority select: scanning high to low lets the lowest visible index win
  always_comb begin
    pix = background_color;
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (layer_pe[i] && act_en[i] && !(act_key && layer_color[i*COLOR_W +: COLOR_W] == KEY_COLOR))
        pix = layer_color[i*COLOR_W +: COLOR_W];
  end
  // Stage 1 captures the blanked composite with sync/DE; later stages only delay
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < PIPE_STAGES; s++) pipe[s] <= IDLE;
    end else begin
      pipe[0] <= {raw_hsync, raw_vsync, raw_de, raw_de ? pix : {COLOR_W{1'b0}}};
      for (int s = 1; s < PIPE_STAGES; s++) pipe[s] <= pipe[s-1];
    end
  end
  assign {vga_hsync, vga_vsync, vga_de, vga_rgb} = pipe[PIPE_STAGES-1];
endmodule

// File: tb/tb_vga_compositor.sv
// tb_vga_compositor: directed checks of priority, keying, deferred config, blanking, wrap and reset
module tb_vga_compositor;
  logic pix_clk = 1'b0;
  logic rst = 1'b1;
  logic raw_hsync = 1'b1, raw_vsync = 1'b1, raw_de = 1'b0, new_frame = 1'b0;
  logic [3:0] layer_pe = '0;
  logic [63:0] layer_color = '0;
  logic [15:0] background_color = '0;
  logic cfg_valid = 1'b0, cfg_key_en = 1'b0;
  logic [3:0] cfg_layer_en = '0;
  logic cfg_pending;
  logic [3:0] active_layer_en;
  logic [15:0] frame_count;
  logic vga_hsync, vga_vsync, vga_de;
  logic [15:0] vga_rgb;
  int checks = 0, errors = 0;
  logic [15:0] exp_fc = 16'd0;

  vga_compositor dut (
    .pix_clk(pix_clk), .rst(rst), .raw_hsync(raw_hsync), .raw_vsync(raw_vsync),
    .raw_de(raw_de), .new_frame(new_frame), .layer_pe(layer_pe), .layer_color(layer_color),
    .background_color(background_color), .cfg_valid(cfg_valid), .cfg_layer_en(cfg_layer_en),
    .cfg_key_en(cfg_key_en), .cfg_pending(cfg_pending), .active_layer_en(active_layer_en),
    .frame_count(frame_count), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
    .vga_rgb(vga_rgb)
  );

  always #5 pix_clk = ~pix_clk;

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if ({vga_hsync, vga_vsync, vga_de} !== 3'b110) begin errors++; $display("FAIL reset_sync got %b exp 110", {vga_hsync, vga_vsync, vga_de}); end
    checks++; if (vga_rgb !== 16'h0000) begin errors++; $display("FAIL reset_rgb got %h exp 0000", vga_rgb); end
    checks++; if (frame_count !== 16'h0000) begin errors++; $display("FAIL reset_fc got %h exp 0000", frame_count); end
    checks++; if (active_layer_en !== 4'hF) begin errors++; $display("FAIL reset_en got %h exp F", active_layer_en); end
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pend got %b exp 0", cfg_pending); end
    rst = 1'b0;
    tick(); tick();
    raw_de = 1'b1; raw_hsync = 1'b0; raw_vsync = 1'b0; background_color = 16'h07E0;
    tick();
    checks++; if ({vga_hsync, vga_de} !== 2'b10) begin errors++; $display("FAIL latency_early got %b exp 10", {vga_hsync, vga_de}); end
    tick();
    checks++; if ({vga_hsync, vga_vsync, vga_de} !== 3'b001) begin errors++; $display("FAIL latency_sync got %b exp 001", {vga_hsync, vga_vsync, vga_de}); end
    checks++; if (vga_rgb !== 16'h07E0) begin errors++; $display("FAIL bg_rgb got %h exp 07E0", vga_rgb); end
  endtask

  task automatic test_priority();
    layer_color = {16'h5555, 16'hF800, 16'h001F, 16'hAAAA};
    layer_pe = 4'b0110;
    tick(); tick();
    checks++; if (vga_rgb !== 16'h001F) begin errors++; $display("FAIL prio_l1 got %h exp 001F", vga_rgb); end
    layer_pe = 4'b0100;
    tick(); tick();
    checks++; if (vga_rgb !== 16'hF800) begin errors++; $display("FAIL prio_l2 got %h exp F800", vga_rgb); end
    layer_pe = 4'b1111;
    tick(); tick();
    checks++; if (vga_rgb !== 16'hAAAA) begin errors++; $display("FAIL prio_l0 got %h exp AAAA", vga_rgb); end
    layer_pe = 4'b1000;
    tick(); tick();
    checks++; if (vga_rgb !== 16'h5555) begin errors++; $display("FAIL prio_l3 got %h exp 5555", vga_rgb); end
  endtask

  task automatic test_key();
    cfg_valid = 1'b1; cfg_layer_en = 4'hF; cfg_key_en = 1'b1; new_frame = 1'b1;
    tick();
    exp_fc++;
    cfg_valid = 1'b0; new_frame = 1'b0;
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL same_cycle_pend got %b exp 0", cfg_pending); end
    layer_color = {16'h1234, 16'hF800, 16'h001F, 16'hF81F};
    layer_pe = 4'b1001;
    tick(); tick();
    checks++; if (vga_rgb !== 16'h1234) begin errors++; $display("FAIL key_fallthrough got %h exp 1234", vga_rgb); end
    layer_pe = 4'b0001;
    tick(); tick();
    checks++; if (vga_rgb !== 16'h07E0) begin errors++; $display("FAIL key_to_bg got %h exp 07E0", vga_rgb); end
    cfg_valid = 1'b1; cfg_key_en = 1'b0; new_frame = 1'b1; layer_pe = 4'b1001;
    tick();
    exp_fc++;
    cfg_valid = 1'b0; new_frame = 1'b0;
    tick(); tick();
    checks++; if (vga_rgb !== 16'hF81F) begin errors++; $display("FAIL key_off got %h exp F81F", vga_rgb); end
    checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL fc_count got %h exp %h", frame_count, exp_fc); end
  endtask

  task automatic test_deferred();
    layer_color = {16'h1234, 16'hF800, 16'h001F, 16'hAAAA};
    layer_pe = 4'b0001;
    cfg_valid = 1'b1; cfg_layer_en = 4'b1111;
    tick();
    cfg_layer_en = 4'b1110;
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL defer_pend got %b exp 1", cfg_pending); end
    checks++; if (active_layer_en !== 4'hF) begin errors++; $display("FAIL defer_en_hold got %h exp F", active_layer_en); end
    tick();
    checks++; if (vga_rgb !== 16'hAAAA) begin errors++; $display("FAIL defer_l0_shown got %h exp AAAA", vga_rgb); end
    new_frame = 1'b1;
    tick();
    exp_fc++;
    new_frame = 1'b0;
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL applied_pend got %b exp 0", cfg_pending); end
    checks++; if (active_layer_en !== 4'b1110) begin errors++; $display("FAIL applied_en got %b exp 1110", active_layer_en); end
    tick();
    checks++; if (vga_rgb !== 16'hAAAA) begin errors++; $display("FAIL nf_pixel_old_cfg got %h exp AAAA", vga_rgb); end
    tick();
    checks++; if (vga_rgb !== 16'h07E0) begin errors++; $display("FAIL l0_hidden got %h exp 07E0", vga_rgb); end
    cfg_valid = 1'b1; cfg_layer_en = 4'b0011; new_frame = 1'b1;
    tick();
    exp_fc++;
    cfg_valid = 1'b0; new_frame = 1'b0;
    checks++; if ({cfg_pending, active_layer_en} !== 5'b00011) begin errors++; $display("FAIL immediate_apply got %b exp 00011", {cfg_pending, active_layer_en}); end
  endtask

  task automatic test_blank_wrap();
    raw_de = 1'b0; layer_pe = 4'b0001;
    tick(); tick();
    checks++; if ({vga_de, vga_rgb} !== 17'h0) begin errors++; $display("FAIL blank got %h exp 0", {vga_de, vga_rgb}); end
    new_frame = 1'b1;
    while (exp_fc != 16'hFFFF) begin
      tick();
      exp_fc++;
    end
    new_frame = 1'b0;
    tick();
    checks++; if (frame_count !== 16'hFFFF) begin errors++; $display("FAIL fc_max got %h exp FFFF", frame_count); end
    new_frame = 1'b1;
    tick();
    exp_fc++;
    new_frame = 1'b0;
    checks++; if (frame_count !== 16'h0000) begin errors++; $display("FAIL fc_wrap got %h exp 0000", frame_count); end
  endtask

  task automatic test_async_reset();
    raw_de = 1'b1; raw_hsync = 1'b0; raw_vsync = 1'b0; layer_pe = 4'b0000;
    cfg_valid = 1'b1; cfg_layer_en = 4'b0000;
    tick();
    cfg_valid = 1'b0;
    tick();
    checks++; if ({cfg_pending, vga_de, vga_hsync} !== 3'b110) begin errors++; $display("FAIL pre_reset got %b exp 110", {cfg_pending, vga_de, vga_hsync}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({vga_hsync, vga_vsync, vga_de} !== 3'b110 || vga_rgb !== 16'h0) begin errors++; $display("FAIL async_out got %b/%h exp 110/0000", {vga_hsync, vga_vsync, vga_de}, vga_rgb); end
    checks++; if ({cfg_pending, active_layer_en} !== 5'b01111) begin errors++; $display("FAIL async_cfg got %b exp 01111", {cfg_pending, active_layer_en}); end
    tick();
    rst = 1'b0; exp_fc = 16'd0;
    new_frame = 1'b1;
    tick();
    exp_fc++;
    new_frame = 1'b0;
    checks++; if (active_layer_en !== 4'hF) begin errors++; $display("FAIL pend_discarded got %h exp F", active_layer_en); end
    checks++; if (frame_count !== exp_fc) begin errors++; $display("FAIL fc_after_reset got %h exp %h", frame_count, exp_fc); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_key();
    test_deferred();
    test_blank_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
